// File: rtl/seizure_pkg.sv
// Shared types and constants for the EEG frame sequencer and its detector interface.
// Q8.8 samples, sequencer state encoding and detector status codes.
package seizure_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int FEATURE_COUNT = 178;

    localparam logic [15:0] Q88_ZERO = 16'h0000;
    localparam logic [15:0] Q88_HALF = 16'h0080;
    localparam logic [15:0] Q88_ONE  = 16'h0100;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARM   = 2'd1,
        PULSE = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        DET_IDLE    = 2'd0,
        DET_BUSY    = 2'd1,
        DET_DONE    = 2'd2,
        DET_TIMEOUT = 2'd3
    } det_status_t;

endpackage

// File: rtl/eeg_frame_sequencer_sat_counter.sv
// Saturating up-counter used for the frame statistics.
// Holds at all-ones instead of wrapping; clear is synchronous.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eeg_frame_sequencer.sv
// Assembles serial EEG samples into a frame, hands it to the detector with a
// one-cycle data_valid pulse, and records the returned classification.
module eeg_frame_sequencer
    import seizure_pkg::*;
#(
    parameter int DATA_WIDTH     = seizure_pkg::DATA_WIDTH,
    parameter int FEATURE_COUNT  = seizure_pkg::FEATURE_COUNT,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      sample_valid,
    input  logic [DATA_WIDTH-1:0]                     sample_data,
    output logic                                      sample_ready,
    input  logic                                      system_ready,
    input  logic                                      result_valid,
    input  logic                                      seizure_detected,
    input  logic [DATA_WIDTH-1:0]                     detection_confidence,
    output logic                                      data_valid,
    output logic [FEATURE_COUNT-1:0][DATA_WIDTH-1:0]  eeg_data,
    output logic                                      alarm,
    output logic [DATA_WIDTH-1:0]                     last_confidence,
    output logic [COUNT_WIDTH-1:0]                    frames_done,
    output logic [COUNT_WIDTH-1:0]                    seizure_count,
    output logic                                      timeout_err,
    output logic                                      busy
);

    localparam int IDX_W = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURE_COUNT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_t                               state_q, state_d;
    logic [IDX_W-1:0]                         wr_idx_q, wr_idx_d;
    logic [TMR_W-1:0]                         timer_q, timer_d;
    logic                                     alarm_q, alarm_d;
    logic [DATA_WIDTH-1:0]                    conf_q, conf_d;
    logic                                     terr_q, terr_d;
    logic [FEATURE_COUNT-1:0][DATA_WIDTH-1:0] frame_q;
    logic                                     accept;
    logic                                     frame_inc;
    logic                                     seiz_inc;

    assign accept = sample_valid && (state_q == FILL);

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        timer_d   = timer_q;
        alarm_d   = alarm_q;
        conf_d    = conf_q;
        terr_d    = terr_q;
        frame_inc = 1'b0;
        seiz_inc  = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = ARM;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            ARM: begin
                if (system_ready) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                // Any result_valid seen here belongs to an earlier request.
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (result_valid) begin
                    alarm_d   = seizure_detected;
                    conf_d    = detection_confidence;
                    frame_inc = 1'b1;
                    seiz_inc  = seizure_detected;
                    state_d   = FILL;
                end else if (timer_q == TMR_MAX) begin
                    terr_d  = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            timer_q  <= '0;
            alarm_q  <= 1'b0;
            conf_q   <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            timer_q  <= timer_d;
            alarm_q  <= alarm_d;
            conf_q   <= conf_d;
            terr_q   <= terr_d;
        end
    end

    // The frame only changes while filling, so the detector sees it stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (accept) begin
            frame_q[wr_idx_q] <= sample_data;
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_frames_done (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_inc),
        .clear (1'b0),
        .count (frames_done)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_seizure_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (seiz_inc),
        .clear (1'b0),
        .count (seizure_count)
    );

    assign sample_ready    = (state_q == FILL);
    assign data_valid      = (state_q == PULSE);
    assign busy            = (state_q != FILL);
    assign eeg_data        = frame_q;
    assign alarm           = alarm_q;
    assign last_confidence = conf_q;
    assign timeout_err     = terr_q;

endmodule

// File: tb/tb_eeg_frame_sequencer.sv
// Scoreboard bench for eeg_frame_sequencer: stimulus queues expected frame
// issues and completions; a negedge monitor pops and compares them.
module tb_eeg_frame_sequencer;

    localparam int DW = 16;
    localparam int FC = 178;
    localparam int TO = 16;
    localparam int CW = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       sample_valid;
    logic [DW-1:0]              sample_data;
    logic                       sample_ready;
    logic                       system_ready;
    logic                       result_valid;
    logic                       seizure_detected;
    logic [DW-1:0]              detection_confidence;
    logic                       data_valid;
    logic [FC-1:0][DW-1:0]      eeg_data;
    logic                       alarm;
    logic [DW-1:0]              last_confidence;
    logic [CW-1:0]              frames_done;
    logic [CW-1:0]              seizure_count;
    logic                       timeout_err;
    logic                       busy;

    eeg_frame_sequencer #(
        .DATA_WIDTH     (DW),
        .FEATURE_COUNT  (FC),
        .TIMEOUT_CYCLES (TO),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sample_valid         (sample_valid),
        .sample_data          (sample_data),
        .sample_ready         (sample_ready),
        .system_ready         (system_ready),
        .result_valid         (result_valid),
        .seizure_detected     (seizure_detected),
        .detection_confidence (detection_confidence),
        .data_valid           (data_valid),
        .eeg_data             (eeg_data),
        .alarm                (alarm),
        .last_confidence      (last_confidence),
        .frames_done          (frames_done),
        .seizure_count        (seizure_count),
        .timeout_err          (timeout_err),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        int unsigned base;
    } issue_t;

    typedef struct {
        int unsigned cyc;
        logic        alarm;
        logic [15:0] conf;
        int unsigned fd;
        int unsigned sc;
        logic        terr;
    } done_t;

    issue_t issue_q[$];
    done_t  done_q[$];

    logic        exp_alarm;
    logic [15:0] exp_conf;
    int unsigned exp_fd;
    int unsigned exp_sc;
    logic        exp_terr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int frame_bad(input int unsigned base);
        for (int i = 0; i < FC; i++) begin
            if (eeg_data[i] !== 16'(base + i)) return i;
        end
        return -1;
    endfunction

    function automatic int unsigned sat3(input int unsigned x);
        return (x > 3) ? 3 : x;
    endfunction

    // Monitor
    logic                  busy_prev = 1'b0;
    logic [FC-1:0][DW-1:0] snap;
    int                    sr_viol = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (busy && sample_ready) sr_viol++;
            if (data_valid) begin
                if (issue_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    issue_t it;
                    it = issue_q.pop_front();
                    chk("dv_cycle", cyc, it.cyc);
                    chk("frame_first_bad_index", frame_bad(it.base), -1);
                    snap = eeg_data;
                end
            end
            if (busy_prev && !busy) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wait_exit: got exit expected none (cycle %0d)", cyc);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("exit_cycle", cyc, d.cyc);
                    chk("alarm", alarm, d.alarm);
                    chk("last_confidence", last_confidence, d.conf);
                    chk("frames_done", frames_done, d.fd);
                    chk("seizure_count", seizure_count, d.sc);
                    chk("timeout_err", timeout_err, d.terr);
                    chk("frame_stable", eeg_data == snap, 1);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic model_reset();
        exp_alarm = 1'b0;
        exp_conf  = '0;
        exp_fd    = 0;
        exp_sc    = 0;
        exp_terr  = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_sample_ready", sample_ready, 1);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_last_confidence", last_confidence, 0);
        chk("rst_frames_done", frames_done, 0);
        chk("rst_seizure_count", seizure_count, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_eeg_data_zero", eeg_data == '0, 1);
    endtask

    // Called #1 after a posedge; returns #1 after a posedge with rst low.
    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_sample(input logic [15:0] v, output int unsigned acc);
        int unsigned n;
        n = 0;
        sample_valid = 1'b1;
        sample_data  = v;
        @(negedge clk);
        while (!sample_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            checks++;
            errors++;
            $display("FAIL sample_accept_wait: got no ready expected ready within 1000 cycles");
        end
        acc = cyc;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_frame(input int unsigned base, input int unsigned first,
                              input int unsigned count, input bit gapped,
                              output int unsigned last_acc);
        for (int unsigned i = first; i < first + count; i++) begin
            send_sample(16'(base + i), last_acc);
            if (gapped) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_exit: got busy expected idle within 100 cycles");
        end else begin
            chk("ready_after_wait", sample_ready, 1);
        end
        @(posedge clk);
        #1;
    endtask

    // Waits for the issue pulse, queues the completion, then answers after
    // k WAIT cycles (give=1) or lets the frame time out (give=0).
    task automatic respond(input int unsigned k, input bit give, input logic sz, input logic [15:0] cf);
        int unsigned n;
        done_t d;
        n = 0;
        @(negedge clk);
        while (!data_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!data_valid) begin
            checks++;
            errors++;
            $display("FAIL dv_wait: got no data_valid expected pulse within 200 cycles");
            result_valid = 1'b0;
            return;
        end
        if (give) begin
            exp_alarm = sz;
            exp_conf  = cf;
            exp_fd    = sat3(exp_fd + 1);
            if (sz) exp_sc = sat3(exp_sc + 1);
            d.cyc = cyc + 2 + k;
        end else begin
            exp_terr = 1'b1;
            d.cyc = cyc + 2 + (TO - 1);
        end
        d.alarm = exp_alarm;
        d.conf  = exp_conf;
        d.fd    = exp_fd;
        d.sc    = exp_sc;
        d.terr  = exp_terr;
        done_q.push_back(d);
        @(posedge clk);
        #1;
        result_valid     = 1'b0;
        seizure_detected = 1'b0;
        if (give) begin
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            result_valid         = 1'b1;
            seizure_detected     = sz;
            detection_confidence = cf;
            @(posedge clk);
            #1;
            result_valid     = 1'b0;
            seizure_detected = 1'b0;
        end
        wait_idle();
    endtask

    task automatic issue_expect(input int unsigned at, input int unsigned base);
        issue_t it;
        it.cyc  = at;
        it.base = base;
        issue_q.push_back(it);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned last;
        rst                  = 1'b1;
        sample_valid         = 1'b0;
        sample_data          = '0;
        system_ready         = 1'b0;
        result_valid         = 1'b0;
        seizure_detected     = 1'b0;
        detection_confidence = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contiguous frame, detector ready; seizure result at WAIT cycle 10
        system_ready = 1'b1;
        send_frame(0, 0, FC, 1'b0, last);
        issue_expect(last + 2, 0);
        respond(10, 1'b1, 1'b1, 16'h00C0);

        // Detector busy for 50 cycles with a sample held on the input
        system_ready = 1'b0;
        send_frame(1000, 0, FC, 1'b0, last);
        sample_valid = 1'b1;
        sample_data  = 16'hDEAD;
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("arm_hold_busy", busy, 1);
        chk("arm_hold_ready", sample_ready, 0);
        @(posedge clk);
        #1;
        system_ready = 1'b1;
        sample_valid = 1'b0;
        issue_expect(cyc + 1, 1000);
        respond(3, 1'b1, 1'b0, 16'h0040);

        // Timeout; a stale result during ARM/PULSE must be ignored
        send_frame(2000, 0, FC, 1'b0, last);
        issue_expect(last + 2, 2000);
        result_valid         = 1'b1;
        seizure_detected     = 1'b1;
        detection_confidence = 16'hFFFF;
        respond(0, 1'b0, 1'b0, 16'h0000);
        chk("timeout_sticky", timeout_err, 1);

        // Result coinciding with the final WAIT cycle wins over timeout
        pulse_reset();
        send_frame(3000, 0, FC, 1'b0, last);
        issue_expect(last + 2, 3000);
        respond(TO - 1, 1'b1, 1'b1, 16'h0100);

        // Gapped fill interrupted by reset after sample 90
        send_frame(4000, 0, 91, 1'b1, last);
        pulse_reset();
        send_frame(5000, 0, FC - 1, 1'b1, last);
        @(negedge clk);
        chk("needs_full_frame_busy", busy, 0);
        chk("needs_full_frame_ready", sample_ready, 1);
        @(posedge clk);
        #1;
        send_frame(5000, FC - 1, 1, 1'b0, last);
        issue_expect(last + 2, 5000);
        respond(0, 1'b1, 1'b1, 16'h0200);

        // Four more seizure frames drive both counters into saturation
        for (int unsigned j = 0; j < 4; j++) begin
            send_frame(6000 + j * 200, 0, FC, 1'b0, last);
            issue_expect(last + 2, 6000 + j * 200);
            respond(1, 1'b1, 1'b1, 16'(16'h0300 + j));
        end
        chk("sat_frames_done", frames_done, 3);
        chk("sat_seizure_count", seizure_count, 3);

        repeat (3) @(posedge clk);
        chk("ready_low_while_busy_violations", sr_viol, 0);
        chk("issue_queue_drained", issue_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeg_frame_sequencer.md
Name: eeg_frame_sequencer

Overview:
- Initiator side of the detector's frame handshake.
- Accepts a serial EEG sample stream (one Q8.8 sample per transfer) and assembles a FEATURE_COUNT-sample frame.
- Issues the frame to the seizure detection system with a one-cycle data_valid pulse once system_ready is high, then holds the frame stable until the result returns.
- Captures the result, keeps frame, seizure and timeout statistics, then refills.

Parameters:
- DATA_WIDTH, 16, sample width (Q8.8 fixed point).
- FEATURE_COUNT, 178, samples per frame.
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles allowed before a frame is abandoned.
- COUNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sample_valid  in  1  input sample present
- sample_data  in  DATA_WIDTH  input sample
- sample_ready  out  1  block can accept a sample
- system_ready  in  1  detector idle and ready for a frame
- result_valid  in  1  detector result present
- seizure_detected  in  1  detector classification
- detection_confidence  in  DATA_WIDTH  detector confidence
- data_valid  out  1  frame-issue pulse to detector
- eeg_data  out  [FEATURE_COUNT-1:0][DATA_WIDTH]  frame to detector
- alarm  out  1  classification of the last completed frame
- last_confidence  out  DATA_WIDTH  confidence of the last completed frame
- frames_done  out  COUNT_WIDTH  completed frames, saturating
- seizure_count  out  COUNT_WIDTH  frames classified as seizure, saturating
- timeout_err  out  1  sticky flag: a frame was abandoned
- busy  out  1  high whenever state is not FILL

Behaviour:
- Reset (async, rst=1):
  - state=FILL, wr_idx=0, timer=0.
  - All outputs 0, including eeg_data, with one exception: sample_ready=1 (it is a Moore output of FILL).
  - Reset mid-frame discards the partial frame and any outstanding request.
- States (Moore outputs):
  - FILL: sample_ready=1.
  - ARM: waiting for system_ready.
  - PULSE: data_valid=1.
  - WAIT: waiting for result_valid.
- FILL:
  - A transfer occurs on sample_valid & sample_ready. It writes eeg_data[wr_idx] and increments wr_idx. The first sample of a frame lands in index 0.
  - When the transfer writes index FEATURE_COUNT-1, wr_idx returns to 0 and the next state is ARM.
- ARM:
  - sample_ready=0.
  - If system_ready=1, the next state is PULSE; otherwise stay in ARM indefinitely (no timeout in ARM).
- PULSE:
  - data_valid=1 for exactly this one cycle; the next state is WAIT and timer is cleared.
  - result_valid is ignored in this cycle (treated as stale).
- WAIT:
  - timer increments each cycle.
  - If result_valid=1: alarm<=seizure_detected, last_confidence<=detection_confidence, frames_done+=1, seizure_count+=1 if seizure_detected; next state FILL.
  - Else if timer==TIMEOUT_CYCLES-1: timeout_err<=1; frames_done and seizure_count unchanged; alarm and last_confidence hold; next state FILL (frame dropped).
  - result_valid and timeout in the same cycle: the result wins and timeout_err is not set.
- Latency: final sample accepted in cycle N -> ARM in N+1 -> if system_ready is high in N+1, data_valid is high in N+2.
- Frame stability: eeg_data is written only in FILL. It is unchanged from the last sample accepted through the end of WAIT, because the detector reads it while processing.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- timeout_err clears only on reset.
- wr_idx width: $clog2(FEATURE_COUNT). timer width: $clog2(TIMEOUT_CYCLES).

Decomposition:
- Shared package seizure_pkg holds:
  - DATA_WIDTH, FEATURE_COUNT and Q8.8 constants (e.g. Q88_HALF=16'h0080).
  - seq_state_t enum {FILL, ARM, PULSE, WAIT}.
  - Detector status codes shared with the top level.
- One sub-module: sat_counter (parameter WIDTH; ports inc, clear, count). It is instantiated twice, for frames_done and seizure_count.

Test Plan:
1. Reset, then stream 178 samples with value i, system_ready=1 -> data_valid high exactly 2 cycles after sample 177; eeg_data[i]==i; sample_ready=0 from the cycle after the last accept until WAIT exits.
2. Frame complete with system_ready=0 for 50 cycles -> state stays ARM; no data_valid until 1 cycle after system_ready rises; no sample accepted during the hold.
3. result_valid=1, seizure_detected=1, confidence=16'h00C0 at WAIT cycle 10 -> alarm=1, last_confidence=16'h00C0, frames_done=1, seizure_count=1; sample_ready=1 next cycle.
4. No result, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles, frames_done unchanged, return to FILL. Repeat with result_valid at cycle 15 -> result captured, timeout_err=0.
5. Gapped sample_valid (toggle every cycle) during fill, with rst pulsed after sample 90 -> all outputs back to reset values; the next frame starts at index 0 and needs 178 new samples.
6. COUNT_WIDTH=2, run 5 seizure frames -> frames_done and seizure_count saturate at 3.
